im_port_arbiter: RTL and testbench
==================================

# im_port_arbiter

Arbitrates the single-port synchronous instruction block RAM between the CPU fetch stage and the boot/debug loader that writes program words. Checks every address against the instruction window and alignment, converts bad fetches into an address-error response without touching the RAM, and sequences the RAM's one-cycle read latency into a request/ready handshake. Sits between the F-stage PC logic, the loader, and the IM BRAM.

## Interface
- `BASE_ADDR`, 32'h0000_3000, byte address of IM word 0
- `DEPTH_WORDS`, 2048, IM size in words; the legal window is `BASE_ADDR` .. `BASE_ADDR + 4*DEPTH_WORDS - 1`
- `ADDR_W`, 11, BRAM word-address width; must equal clog2(`DEPTH_WORDS`)
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  fetch request; held high with `cpu_addr` stable until `cpu_ready`
- `cpu_addr`  in  32  fetch byte address
- `cpu_ready`  out  1  one-cycle pulse; fetch complete
- `cpu_instr`  out  32  instruction word; valid only while `cpu_ready` is high
- `cpu_adel`  out  1  valid with `cpu_ready`; the fetch address was illegal
- `ld_req`  in  1  loader write request; held high with `ld_addr`/`ld_wdata` stable until `ld_ack`
- `ld_addr`  in  32  write byte address
- `ld_wdata`  in  32  write data
- `ld_ack`  out  1  one-cycle pulse; write complete
- `ld_err`  out  1  valid with `ld_ack`; the address was illegal and nothing was written
- `bram_en`  out  1  BRAM enable
- `bram_we`  out  1  BRAM write enable
- `bram_addr`  out  `ADDR_W`  BRAM word address, `(addr - BASE_ADDR) >> 2`
- `bram_wdata`  out  32  BRAM write data
- `bram_rdata`  in  32  BRAM read data, valid one cycle after an enabled read

## Operation
- An address is legal iff `BASE_ADDR <= addr <= BASE_ADDR + 4*DEPTH_WORDS - 1` and `addr[1:0] == 0`. The comparison is unsigned on 32 bits, with no wrap.
- FSM states: IDLE, FETCH, WRITE.
- IDLE, accepting a CPU request: latch the legality flag.
  - Legal: drive `bram_en=1`, `bram_we=0`, `bram_addr`, then go to FETCH.
  - Illegal: `bram_en=0`, then go to FETCH.
- IDLE, accepting a loader request:
  - Legal: `bram_en=1`, `bram_we=1`, `bram_addr`, `bram_wdata=ld_wdata`, then go to WRITE.
  - Illegal: no enable, then go to WRITE.
- FETCH:
  - `cpu_ready=1`.
  - `cpu_instr` is `bram_rdata` when legal, 32'h0 when illegal.
  - `cpu_adel` is set to the latched flag.
  - Go to IDLE.
- WRITE: `ld_ack=1`, `ld_err` set to the latched flag, then go to IDLE.
- Arbitration, applied only in IDLE:
  - With a single requester, that requester is granted.
  - If both request, the grant is round-robin: a 1-bit `last_grant` register makes the requester not granted last time win.
  - `last_grant` resets to CPU, so the loader wins the first tie.
- No request is accepted in FETCH or WRITE.
- A request raised in those states waits until the next IDLE cycle.

## Timing
- Reset values: every output is 0; state is IDLE; `last_grant` is CPU; the latched flag is 0.
- Async reset mid-transaction:
  - The transaction is dropped and no ack/ready is issued.
  - A write already issued to the BRAM in the accept cycle may have landed.
  - Requesters re-issue after reset.
- Accept in cycle N gives response in cycle N+1; each transaction occupies 2 cycles.
- Sustained throughput is one transaction per 2 cycles.
- Under sustained contention, CPU and loader alternate and each completes one transaction per 4 cycles.
- Write then read of the same word: the write is accepted at N and acked at N+1; the read is accepted at N+2 at the earliest and returns the new data at N+3.
- `bram_en`/`bram_we` are high only in the accept cycle of a legal transaction.
- Requester deasserting `req` before its ready/ack is a protocol violation; behaviour is undefined.

## Configuration
- `IM_LOADER_EN` defined: full behaviour as above.
- `IM_LOADER_EN` undefined:
  - WRITE state and `last_grant` are removed.
  - `ld_*` inputs are ignored; `ld_ack` and `ld_err` are tied to 0; `bram_we` is tied to 0.
  - The CPU is always granted.

## Structure
- Shared package holds:
  - the default `BASE_ADDR` and `DEPTH_WORDS`;
  - the FSM state encoding (IDLE=2'd0, FETCH=2'd1, WRITE=2'd2);
  - the grant encoding (CPU=0, LD=1).
- One sub-module, `im_addr_check`: purely combinational legality check plus word-address translation, instantiated once per requester.

## Test plan
- Reset, then `cpu_req` at 32'h3000 with BRAM word 0 = 32'h2408_0001 -> `bram_en` pulses with `bram_addr=0`; the next cycle gives `cpu_ready=1`, `cpu_instr=32'h2408_0001`, `cpu_adel=0`.
- `cpu_req` at 32'h3002, 32'h2ffc and 32'h5000 -> no `bram_en`; `cpu_ready=1`, `cpu_adel=1`, `cpu_instr=0` each time.
- Loader writes 32'hdead_beef to 32'h4ffc, then CPU reads 32'h4ffc -> `bram_we` with `bram_addr=2047`; `ld_ack=1`, `ld_err=0`; the read returns 32'hdead_beef.
- Loader write to 32'h5000 -> `ld_ack=1`, `ld_err=1`, `bram_we` never asserted.
- CPU and loader requesting continuously from reset -> grants LD, CPU, LD, CPU, … with `last_grant` alternating and no starvation.
- `reset_n` pulled low in a FETCH cycle -> `cpu_ready` stays 0; state is IDLE after release; the re-issued fetch completes normally.

Source files
------------

// File: rtl/im_port_arbiter_pkg.sv
// Shared defaults and encodings for the instruction-memory port arbiter.
package im_port_arbiter_pkg;

  localparam logic [31:0] IM_BASE_ADDR   = 32'h0000_3000;
  localparam int          IM_DEPTH_WORDS = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LD  = 1'b1
  } grant_e;

endpackage

// File: rtl/im_addr_check.sv
// Combinational IM window/alignment check and byte-to-word address translation.
module im_addr_check
  import im_port_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IM_BASE_ADDR,
  parameter int          DEPTH_WORDS = IM_DEPTH_WORDS,
  parameter int          ADDR_W      = 11
) (
  input  logic [31:0]       addr,
  output logic              legal,
  output logic [ADDR_W-1:0] waddr
);

  // 33-bit upper bound so a window ending at the top of the address space cannot wrap
  localparam logic [32:0] LAST = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;

  assign legal = (addr >= BASE_ADDR) && ({1'b0, addr} <= LAST) && (addr[1:0] == 2'b00);
  assign waddr = ADDR_W'((addr - BASE_ADDR) >> 2);

endmodule

// File: rtl/im_port_arbiter.sv
// Arbitrates the single-port IM BRAM between CPU fetch and the boot/debug loader.
// IM_LOADER_EN enables the loader write path; undefined, the CPU owns the port.
module im_port_arbiter
  import im_port_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IM_BASE_ADDR,
  parameter int          DEPTH_WORDS = IM_DEPTH_WORDS,
  parameter int          ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  output logic              cpu_ready,
  output logic [31:0]       cpu_instr,
  output logic              cpu_adel,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  output logic              ld_err,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata
);

`ifdef IM_LOADER_EN
  localparam int NUM_REQ = 2;
`else
  localparam int NUM_REQ = 1;
`endif

  logic [NUM_REQ-1:0][31:0]       req_addr;
  logic [NUM_REQ-1:0]             legal;
  logic [NUM_REQ-1:0][ADDR_W-1:0] waddr;

`ifdef IM_LOADER_EN
  assign req_addr = {ld_addr, cpu_addr};
`else
  logic unused_ld;
  assign req_addr[0] = cpu_addr;
  assign unused_ld   = ^{ld_req, ld_addr, ld_wdata};
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    im_addr_check #(
      .BASE_ADDR  (BASE_ADDR),
      .DEPTH_WORDS(DEPTH_WORDS),
      .ADDR_W     (ADDR_W)
    ) u_chk (
      .addr (req_addr[i]),
      .legal(legal[i]),
      .waddr(waddr[i])
    );
  end

  state_e state, state_n;
  logic   bad, bad_n;   // latched "address illegal" flag of the accepted transaction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      bad   <= 1'b0;
    end else begin
      state <= state_n;
      bad   <= bad_n;
    end
  end

`ifdef IM_LOADER_EN
  grant_e last_grant, last_grant_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant <= GNT_CPU;
    else          last_grant <= last_grant_n;
  end
`endif

  always_comb begin
    state_n    = state;
    bad_n      = bad;
    cpu_ready  = 1'b0;
    cpu_instr  = '0;
    cpu_adel   = 1'b0;
    ld_ack     = 1'b0;
    ld_err     = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
`ifdef IM_LOADER_EN
    last_grant_n = last_grant;
`endif
    case (state)
      ST_IDLE: begin
`ifdef IM_LOADER_EN
        // loader wins a tie unless it was the one served last
        if (ld_req && (!cpu_req || last_grant == GNT_CPU)) begin
          bad_n        = !legal[1];
          bram_en      = legal[1];
          bram_we      = legal[1];
          bram_addr    = waddr[1];
          bram_wdata   = ld_wdata;
          last_grant_n = GNT_LD;
          state_n      = ST_WRITE;
        end else
`endif
        if (cpu_req) begin
          bad_n     = !legal[0];
          bram_en   = legal[0];
          bram_addr = waddr[0];
`ifdef IM_LOADER_EN
          last_grant_n = GNT_CPU;
`endif
          state_n   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cpu_ready = 1'b1;
        cpu_adel  = bad;
        cpu_instr = bad ? 32'h0 : bram_rdata;
        state_n   = ST_IDLE;
      end
`ifdef IM_LOADER_EN
      ST_WRITE: begin
        ld_ack  = 1'b1;
        ld_err  = bad;
        state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Self-checking bench for im_port_arbiter with a behavioural BRAM and transaction model.
module tb_im_port_arbiter;
  import im_port_arbiter_pkg::*;

  localparam int          AW    = 11;
  localparam int          DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef IM_LOADER_EN
  localparam bit LD_EN = 1'b1;
`else
  localparam bit LD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, ld_req;
  logic [31:0]   cpu_addr, ld_addr, ld_wdata;
  logic          cpu_ready, cpu_adel, ld_ack, ld_err;
  logic [31:0]   cpu_instr;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata, bram_rdata;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;

  logic [31:0] ram     [DEPTH];
  logic [31:0] exp_mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;
  bit m_last_ld;   // model: loader was the requester served most recently

  always #5 clk = ~clk;

  im_port_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_instr(cpu_instr), .cpu_adel(cpu_adel),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_err(ld_err),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // single-port synchronous BRAM, read-first, plus a bench preload path
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bram_en) begin
      if (bram_we) ram[bram_addr] <= bram_wdata;
      bram_rdata <= ram[bram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h2408_0001 ^ (32'(i) << 16);
  endfunction

  function automatic bit is_legal(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH)) && (a % 4 == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      2:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      default: a = $urandom_range(0, 1) ? ($urandom_range(0, BASE - 1) & 32'hffff_fffc)
                                        : (BASE + 32'(4 * DEPTH) + ($urandom & 32'h0fff_fffc));
    endcase
    return a;
  endfunction

  // Present one or both requests at posedge+1 and follow them to completion.
  task automatic run_round(input bit c, input bit l, input logic [31:0] ca,
                           input logic [31:0] la, input logic [31:0] d);
    bit pend_c, pend_l, win_ld, lg;
    logic [31:0] a;
    pend_c   = c;
    pend_l   = l && LD_EN;
    cpu_req  = c;  cpu_addr = ca;
    ld_req   = l;  ld_addr  = la;  ld_wdata = d;
    if (!pend_c && !pend_l) begin
      #4;
      check("ignored_en", 32'(bram_en), 32'd0);
      step();
      check("ignored_ack", 32'(ld_ack), 32'd0);
    end
    while (pend_c || pend_l) begin
      win_ld = pend_l && (!pend_c || !m_last_ld);
      a  = win_ld ? la : ca;
      lg = is_legal(a);
      #4;
      check("acc_en", 32'(bram_en), 32'(lg));
      check("acc_we", 32'(bram_we), 32'(lg && win_ld));
      if (lg) check("acc_addr", 32'(bram_addr), 32'(word_of(a)));
      if (lg && win_ld) check("acc_wdata", bram_wdata, d);
      step();
      if (lg && win_ld) exp_mem[word_of(a)] = d;
      #4;
      check("rsp_ready", 32'(cpu_ready), 32'(!win_ld));
      check("rsp_ack", 32'(ld_ack), 32'(win_ld));
      check("rsp_no_accept", 32'(bram_en), 32'd0);
      if (win_ld) check("rsp_err", 32'(ld_err), 32'(!lg));
      else begin
        check("rsp_adel", 32'(cpu_adel), 32'(!lg));
        check("rsp_instr", cpu_instr, lg ? exp_mem[word_of(a)] : 32'h0);
      end
      m_last_ld = win_ld;
      step();
      if (win_ld) begin pend_l = 1'b0; ld_req = 1'b0; end
      else        begin pend_c = 1'b0; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
  endtask

  typedef struct {
    logic [31:0]   addr;
    bit            legal;
    logic [AW-1:0] waddr;
  } vec_t;

  vec_t tab [9];

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0;
    ld_req  = 1'b0; ld_addr  = '0; ld_wdata = '0;
    pre_we  = 1'b0; pre_addr = '0; pre_data = '0;
    m_last_ld = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = init_word(i);
      exp_mem[i] = init_word(i);
      step();
    end
    pre_we = 1'b0;

    #4;
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_instr", cpu_instr, 32'd0);
    check("rst_adel", 32'(cpu_adel), 32'd0);
    check("rst_ack", 32'(ld_ack), 32'd0);
    check("rst_err", 32'(ld_err), 32'd0);
    check("rst_en", 32'(bram_en), 32'd0);
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_wdata", bram_wdata, 32'd0);
    step();
    reset_n = 1'b1;
    #4;
    check("idle_en", 32'(bram_en), 32'd0);
    check("idle_ready", 32'(cpu_ready), 32'd0);
    step();

    tab[0] = '{32'h0000_3000, 1'b1, 11'd0};
    tab[1] = '{32'h0000_3002, 1'b0, 11'd0};
    tab[2] = '{32'h0000_2ffc, 1'b0, 11'd0};
    tab[3] = '{32'h0000_5000, 1'b0, 11'd0};
    tab[4] = '{32'h0000_4ffc, 1'b1, 11'd2047};
    tab[5] = '{32'h0000_3004, 1'b1, 11'd1};
    tab[6] = '{32'hffff_fffc, 1'b0, 11'd0};
    tab[7] = '{32'h0000_0000, 1'b0, 11'd0};
    tab[8] = '{32'h0000_4fff, 1'b0, 11'd0};
    for (int k = 0; k < 9; k++) begin
      cpu_req = 1'b1; cpu_addr = tab[k].addr;
      #4;
      check("tab_en", 32'(bram_en), 32'(tab[k].legal));
      if (tab[k].legal) check("tab_addr", 32'(bram_addr), 32'(tab[k].waddr));
      step();
      #4;
      check("tab_ready", 32'(cpu_ready), 32'd1);
      check("tab_adel", 32'(cpu_adel), 32'(!tab[k].legal));
      check("tab_instr", cpu_instr, tab[k].legal ? exp_mem[tab[k].waddr] : 32'h0);
      step();
      cpu_req = 1'b0;
    end
    check("tab_word0", exp_mem[0], 32'h2408_0001);

    // write then read back the last word; out-of-window write
    run_round(1'b0, 1'b1, 32'h0, 32'h0000_4ffc, 32'hdead_beef);
    run_round(1'b1, 1'b0, 32'h0000_4ffc, 32'h0, 32'h0);
    run_round(1'b0, 1'b1, 32'h0, 32'h0000_5000, 32'h1234_5678);
    run_round(1'b1, 1'b0, 32'h0000_4ffc, 32'h0, 32'h0);

    // continuous contention straight out of reset
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h0000_3000;
    ld_req  = 1'b1; ld_addr  = 32'h0000_3008; ld_wdata = 32'ha5a5_5a5a;
    step();
    step();
    reset_n = 1'b1;
    m_last_ld = 1'b0;
    for (int t = 0; t < 8; t++) begin
      bit w;
      w = LD_EN && !m_last_ld;
      #4;
      check("cont_en", 32'(bram_en), 32'd1);
      check("cont_we", 32'(bram_we), 32'(w));
      step();
      if (w) exp_mem[2] = 32'ha5a5_5a5a;
      #4;
      check("cont_ready", 32'(cpu_ready), 32'(!w));
      check("cont_ack", 32'(ld_ack), 32'(w));
      if (!w) check("cont_instr", cpu_instr, exp_mem[0]);
      m_last_ld = w;
      step();
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    step();

    // reset during the response cycle of a fetch
    cpu_req = 1'b1; cpu_addr = 32'h0000_3004;
    #4;
    check("mid_acc_en", 32'(bram_en), 32'd1);
    step();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("mid_rst_ready", 32'(cpu_ready), 32'd0);
    #3;
    check("mid_rst_ready2", 32'(cpu_ready), 32'd0);
    step();
    reset_n = 1'b1;
    m_last_ld = 1'b0;
    #4;
    check("mid_rel_ready", 32'(cpu_ready), 32'd0);
    check("mid_rel_en", 32'(bram_en), 32'd0);
    step();
    run_round(1'b1, 1'b0, 32'h0000_3004, 32'h0, 32'h0);

    // randomized traffic
    for (int r = 0; r < 300; r++) begin
      bit c, l;
      logic [31:0] ca, la;
      c  = 1'($urandom_range(0, 1));
      l  = 1'($urandom_range(0, 1));
      ca = rand_addr();
      la = (c && $urandom_range(0, 3) == 0) ? ca : rand_addr();
      if (c || l) run_round(c, l, ca, la, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        #4;
        check("gap_en", 32'(bram_en), 32'd0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
